// File: rtl/m_w_load_reg.sv
// M/W pipeline register with load-data alignment and extension for the W stage.
// Also flags misaligned loads (AdEL) combinationally in M.
module m_w_load_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req,
  input  logic [31:0] PC_M,
  input  logic [3:0]  lsOp_M,
  input  logic [31:0] res_M,
  input  logic [31:0] m_data_rdata,
  input  logic [4:0]  A3_M,
  input  logic        regWE_M,
  output logic        AdEL_M,
  output logic [31:0] PC_W,
  output logic [4:0]  A3_W,
  output logic        regWE_W,
  output logic [31:0] WD_W
);

  localparam logic [3:0] OP_LW  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LHU = 4'b0011;
  localparam logic [3:0] OP_LB  = 4'b0100;
  localparam logic [3:0] OP_LBU = 4'b0101;

  logic [3:0]  ls_op_w;
  logic [31:0] res_w;
  logic [31:0] rdata_w;
  logic [1:0]  addr_low2_w;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    AdEL_M = 1'b0;
    if (lsOp_M == OP_LW)
      AdEL_M = (res_M[1:0] != 2'b00);
    else if (lsOp_M == OP_LH || lsOp_M == OP_LHU)
      AdEL_M = res_M[0];
  end

  // Priority: reset > flush (req) > advance (en) > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_W        <= RESET_PC;
      A3_W        <= 5'd0;
      regWE_W     <= 1'b0;
      ls_op_w     <= 4'd0;
      res_w       <= 32'd0;
      rdata_w     <= 32'd0;
      addr_low2_w <= 2'd0;
    end else if (req) begin
      PC_W        <= EXC_PC;
      A3_W        <= 5'd0;
      regWE_W     <= 1'b0;
      ls_op_w     <= 4'd0;
      res_w       <= 32'd0;
      rdata_w     <= 32'd0;
      addr_low2_w <= 2'd0;
    end else if (en) begin
      PC_W        <= PC_M;
      A3_W        <= A3_M;
      regWE_W     <= regWE_M;
      ls_op_w     <= lsOp_M;
      res_w       <= res_M;
      rdata_w     <= m_data_rdata;
      addr_low2_w <= res_M[1:0];
    end
  end

  always_comb begin
    byte_sel = rdata_w[7:0];
    case (addr_low2_w)
      2'd0: byte_sel = rdata_w[7:0];
      2'd1: byte_sel = rdata_w[15:8];
      2'd2: byte_sel = rdata_w[23:16];
      2'd3: byte_sel = rdata_w[31:24];
      default: byte_sel = rdata_w[7:0];
    endcase
    half_sel = addr_low2_w[1] ? rdata_w[31:16] : rdata_w[15:0];
  end

  // Stores and unknown encodings fall through to the registered result.
  always_comb begin
    WD_W = res_w;
    case (ls_op_w)
      OP_LW:   WD_W = rdata_w;
      OP_LH:   WD_W = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  WD_W = {16'd0, half_sel};
      OP_LB:   WD_W = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  WD_W = {24'd0, byte_sel};
      default: WD_W = res_w;
    endcase
  end

endmodule

// File: tb/tb_m_w_load_reg.sv
// Scoreboard bench for m_w_load_reg: driver pushes expectations from a
// behavioural model, independent monitors pop and compare.
module tb_m_w_load_reg;

  logic        clk = 1'b0;
  logic        reset, en, req, regWE_M;
  logic [31:0] PC_M, res_M, m_data_rdata;
  logic [3:0]  lsOp_M;
  logic [4:0]  A3_M;
  logic        AdEL_M, regWE_W;
  logic [31:0] PC_W, WD_W;
  logic [4:0]  A3_W;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  a3;
    logic        we;
    logic [31:0] wd;
  } w_exp_t;

  w_exp_t w_q[$];
  logic   adel_q[$];

  // model state
  logic [31:0] m_pc, m_res, m_rd;
  logic [4:0]  m_a3;
  logic        m_we;
  logic [3:0]  m_op;

  m_w_load_reg dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .PC_M(PC_M), .lsOp_M(lsOp_M),
    .res_M(res_M), .m_data_rdata(m_data_rdata), .A3_M(A3_M), .regWE_M(regWE_M),
    .AdEL_M(AdEL_M), .PC_W(PC_W), .A3_W(A3_W), .regWE_W(regWE_W), .WD_W(WD_W)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_wd(logic [3:0] op, logic [31:0] res, logic [31:0] rd);
    logic [31:0] v;
    int a;
    a = res % 4;
    case (op)
      4'd1: return rd;
      4'd2, 4'd3: begin
        v = (rd >> ((a >= 2) ? 16 : 0)) & 32'h0000_FFFF;
        if (op == 4'd2 && v >= 32'h0000_8000) v = v + 32'hFFFF_0000;
        return v;
      end
      4'd4, 4'd5: begin
        v = (rd >> (8 * a)) & 32'h0000_00FF;
        if (op == 4'd4 && v >= 32'h0000_0080) v = v + 32'hFFFF_FF00;
        return v;
      end
      default: return res;
    endcase
  endfunction

  task automatic apply(input logic rst, input logic e, input logic r, input logic [31:0] pc,
                       input logic [3:0] op, input logic [31:0] res, input logic [31:0] rd,
                       input logic [4:0] a3, input logic we);
    w_exp_t x;
    logic adel;
    @(negedge clk);
    reset = rst; en = e; req = r; PC_M = pc; lsOp_M = op; res_M = res;
    m_data_rdata = rd; A3_M = a3; regWE_M = we;
    adel = 1'b0;
    if (op == 4'd1) adel = (res % 4) != 0;
    if (op == 4'd2 || op == 4'd3) adel = (res % 2) != 0;
    adel_q.push_back(adel);
    if (rst) begin
      m_pc = 32'h0000_3000; m_a3 = 0; m_we = 0; m_op = 0; m_res = 0; m_rd = 0;
    end else if (r) begin
      m_pc = 32'h0000_4180; m_a3 = 0; m_we = 0; m_op = 0; m_res = 0; m_rd = 0;
    end else if (e) begin
      m_pc = pc; m_a3 = a3; m_we = we; m_op = op; m_res = res; m_rd = rd;
    end
    x.pc = m_pc; x.a3 = m_a3; x.we = m_we; x.wd = model_wd(m_op, m_res, m_rd);
    w_q.push_back(x);
  endtask

  // W-stage monitor: samples just after each active edge
  initial begin
    w_exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (w_q.size() > 0) begin
        x = w_q.pop_front();
        vectors++;
        if (PC_W !== x.pc || A3_W !== x.a3 || regWE_W !== x.we || WD_W !== x.wd) begin
          miscompares++;
          $display("FAIL w_stage t=%0t got pc=%h a3=%0d we=%b wd=%h want pc=%h a3=%0d we=%b wd=%h",
                   $time, PC_W, A3_W, regWE_W, WD_W, x.pc, x.a3, x.we, x.wd);
        end
      end
    end
  end

  // M-stage AdEL monitor: samples mid-cycle after inputs settle
  initial begin
    logic a;
    forever begin
      @(negedge clk);
      #1;
      if (adel_q.size() > 0) begin
        a = adel_q.pop_front();
        vectors++;
        if (AdEL_M !== a) begin
          miscompares++;
          $display("FAIL adel t=%0t got %b want %b (op=%h res=%h)", $time, AdEL_M, a, lsOp_M, res_M);
        end
      end
    end
  end

  initial begin
    reset = 1; en = 0; req = 0; PC_M = 0; lsOp_M = 0; res_M = 0;
    m_data_rdata = 0; A3_M = 0; regWE_M = 0;
    m_pc = 0; m_a3 = 0; m_we = 0; m_op = 0; m_res = 0; m_rd = 0;

    apply(1, 0, 0, 32'h0, 4'd0, 32'h0, 32'h0, 5'd0, 0);
    // directed: lb/lbu sign, lh/lhu halves, AdEL cases, non-loads
    apply(0, 1, 0, 32'h3004, 4'd4, 32'h0000_0003, 32'h80AB_CD12, 5'd5, 1);
    apply(0, 1, 0, 32'h3008, 4'd5, 32'h0000_0003, 32'h80AB_CD12, 5'd5, 1);
    apply(0, 1, 0, 32'h300C, 4'd2, 32'h0000_0002, 32'h9234_5678, 5'd6, 1);
    apply(0, 1, 0, 32'h3010, 4'd3, 32'h0000_0002, 32'h9234_5678, 5'd6, 1);
    apply(0, 1, 0, 32'h3014, 4'd2, 32'h0000_0000, 32'h9234_5678, 5'd7, 1);
    apply(0, 1, 0, 32'h3018, 4'd1, 32'h1000_0002, 32'h1111_2222, 5'd8, 1);
    apply(0, 1, 0, 32'h301C, 4'd2, 32'h1000_0001, 32'h1111_2222, 5'd8, 1);
    apply(0, 1, 0, 32'h3020, 4'd4, 32'h1000_0001, 32'h1111_2222, 5'd9, 1);
    apply(0, 1, 0, 32'h3024, 4'd0, 32'hDEAD_BEEF, 32'h5555_5555, 5'd10, 1);
    apply(0, 1, 0, 32'h3028, 4'd6, 32'hDEAD_BEEF, 32'h5555_5555, 5'd11, 0);
    // stall with changing inputs, then flush during stall
    for (int i = 0; i < 3; i++)
      apply(0, 0, 0, $urandom, 4'($urandom_range(0, 8)), $urandom, $urandom, 5'($urandom), 1'($urandom));
    apply(0, 0, 1, 32'h3100, 4'd1, 32'h0, 32'h7777_7777, 5'd12, 1);
    apply(0, 1, 0, 32'h3104, 4'd1, 32'h0, 32'hCAFE_F00D, 5'd13, 1);
    // reset wins over stall and over flush
    apply(1, 0, 0, 32'h3108, 4'd1, 32'h0, 32'h1234_5678, 5'd14, 1);
    apply(0, 1, 0, 32'h310C, 4'd5, 32'h1, 32'h1234_5678, 5'd15, 1);
    apply(1, 1, 1, 32'h3110, 4'd1, 32'h0, 32'h1234_5678, 5'd16, 1);

    for (int i = 0; i < 400; i++)
      apply($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
            $urandom, 4'($urandom_range(0, 10)), $urandom, $urandom, 5'($urandom), 1'($urandom));

    for (int i = 0; i < 10 && (w_q.size() > 0 || adel_q.size() > 0); i++)
      @(posedge clk);
    #2;
    if (w_q.size() > 0 || adel_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", w_q.size() + adel_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
